// File: rtl/interrupt_controller_if.sv
// Interrupt controller bus: source levels, timer/mask configuration and the control-unit handshake.
// Pure wiring; adds no latency.
// No backpressure of its own; the request is held by the controller until ack.
interface interrupt_controller_if #(
  parameter int N_EXT = 3,
  parameter int CNT_W = 16,
  parameter int ID_W  = 2
);
  localparam int N_SRC = N_EXT + 1;

  logic             stop;
  logic [N_EXT-1:0] irq_in;
  logic             quantum_we;
  logic [CNT_W-1:0] quantum_in;
  logic             mask_we;
  logic [N_SRC-1:0] mask_in;
  logic             ack;
  logic             eoi;

  logic             sigint;
  logic [ID_W-1:0]  cause;
  logic [N_SRC-1:0] pending;
  logic             in_service;
  logic [CNT_W-1:0] count;

  // Control unit / IO side
  modport master (
    output stop, irq_in, quantum_we, quantum_in, mask_we, mask_in, ack, eoi,
    input  sigint, cause, pending, in_service, count
  );

  // Controller side
  modport slave (
    input  stop, irq_in, quantum_we, quantum_in, mask_we, mask_in, ack, eoi,
    output sigint, cause, pending, in_service, count
  );
endinterface

// File: rtl/interrupt_controller.sv
// Preemption timer (source 0) plus N_EXT edge-triggered sources, masked fixed-priority request to the control unit.
// Event latches at edge E; sigint rises at E+1 when idle; after eoi at F a still-pending source re-requests at F+1.
// sigint is held with a frozen cause until ack; no nesting while in service, new events keep latching.
module interrupt_controller #(
  parameter int N_EXT           = 3,
  parameter int CNT_W           = 16,
  parameter int QUANTUM_DEFAULT = 1000,
  parameter int ID_W            = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  interrupt_controller_if.slave  bus
);
  localparam int N_SRC = N_EXT + 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state;
  state_t           stateNext;
  logic [ID_W-1:0]  causeReg;
  logic [ID_W-1:0]  causeNext;
  logic [CNT_W-1:0] countReg;
  logic [CNT_W-1:0] quantumReg;
  logic [N_SRC-1:0] maskReg;
  logic [N_SRC-1:0] pendingReg;
  logic [N_EXT-1:0] irqPrev;
  logic [N_SRC-1:0] clearMask;
  logic [N_SRC-1:0] edgeSet;
  logic             timerRun;
  logic             timerExpire;

  // Lowest index wins, so the timer (source 0) has top priority.
  function automatic logic [ID_W-1:0] lowestIndex(input logic [N_SRC-1:0] req);
    lowestIndex = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) lowestIndex = ID_W'(i);
    end
  endfunction

  // Timer runs outside service, unless halted or disabled; a quantum write pre-empts expiry.
  always_comb begin
    timerRun    = (state != SERVICE) && !bus.stop && (quantumReg != '0);
    timerExpire = timerRun && !bus.quantum_we && (countReg == quantumReg - CNT_W'(1));
    edgeSet     = {bus.irq_in & ~irqPrev, timerExpire};
  end

  // Next state, cause capture and the pending bit to retire on ack.
  always_comb begin
    stateNext = state;
    causeNext = causeReg;
    clearMask = '0;
    case (state)
      IDLE: begin
        if ((pendingReg & maskReg) != '0) begin
          stateNext = REQ;
          causeNext = lowestIndex(pendingReg & maskReg);
        end
      end
      REQ: begin
        if (bus.ack) begin
          stateNext = SERVICE;
          clearMask = N_SRC'(1) << causeReg;
        end
      end
      SERVICE: begin
        if (bus.eoi) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State and cause registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      causeReg <= '0;
    end else begin
      state    <= stateNext;
      causeReg <= causeNext;
    end
  end

  // Timer, configuration, edge history and pending latches; a new event beats a same-cycle clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      countReg   <= '0;
      quantumReg <= CNT_W'(QUANTUM_DEFAULT);
      maskReg    <= '1;
      pendingReg <= '0;
      irqPrev    <= '0;
    end else begin
      if (bus.quantum_we) begin
        quantumReg <= bus.quantum_in;
        countReg   <= '0;
      end else if (timerExpire) begin
        countReg   <= '0;
      end else if (timerRun) begin
        countReg   <= countReg + CNT_W'(1);
      end
      if (bus.mask_we) maskReg <= bus.mask_in;
      pendingReg <= (pendingReg & ~clearMask) | edgeSet;
      irqPrev    <= bus.irq_in;
    end
  end

  assign bus.sigint     = (state == REQ);
  assign bus.in_service = (state == SERVICE);
  assign bus.cause      = causeReg;
  assign bus.pending    = pendingReg;
  assign bus.count      = countReg;
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed stimulus for interrupt_controller against a cycle-level behavioural model.
// Model advances on each rising edge from the inputs held across that edge; outputs compared on falling edges.
// Literal checks pin the model at the key points of each scenario.
module tb_interrupt_controller;
  logic clock;
  logic reset;
  int   nTests = 0;
  int   nFail  = 0;
  bit   checkOn = 0;

  interrupt_controller_if #(.N_EXT(3), .CNT_W(16), .ID_W(2)) bus ();

  interrupt_controller #(
    .N_EXT(3), .CNT_W(16), .QUANTUM_DEFAULT(1000), .ID_W(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Model state: phase 0 = nothing requested, 1 = waiting for ack, 2 = handler running.
  logic [15:0] mCount = 0;
  logic [15:0] mQuantum = 1000;
  logic [3:0]  mMask = 4'hF;
  logic [3:0]  mPending = 0;
  logic [2:0]  mPrev = 0;
  int          mPhase = 0;
  int          mCause = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelEdge();
    logic [3:0]  ev;
    logic [3:0]  served;
    logic [15:0] nextCount;
    int          pick;
    if (reset) begin
      mCount = 0; mQuantum = 1000; mMask = 4'hF; mPending = 0;
      mPrev = 0; mPhase = 0; mCause = 0;
      return;
    end
    ev = '0;
    served = '0;
    nextCount = mCount;
    if (bus.quantum_we) nextCount = 0;
    else if (mPhase != 2 && !bus.stop && mQuantum != 0) begin
      if (int'(mCount) + 1 == int'(mQuantum)) begin
        nextCount = 0;
        ev[0] = 1'b1;
      end else begin
        nextCount = mCount + 16'd1;
      end
    end
    for (int i = 0; i < 3; i++) if (bus.irq_in[i] && !mPrev[i]) ev[i+1] = 1'b1;
    case (mPhase)
      0: begin
        pick = -1;
        for (int s = 3; s >= 0; s--) if (mPending[s] && mMask[s]) pick = s;
        if (pick >= 0) begin
          mPhase = 1;
          mCause = pick;
        end
      end
      1: if (bus.ack) begin
        mPhase = 2;
        served[mCause] = 1'b1;
      end
      default: if (bus.eoi) mPhase = 0;
    endcase
    mPending = (mPending & ~served) | ev;
    mCount = nextCount;
    if (bus.quantum_we) mQuantum = bus.quantum_in;
    if (bus.mask_we) mMask = bus.mask_in;
    mPrev = bus.irq_in;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      modelEdge();
      #1;
    end
  endtask

  task automatic serviceOne();
    int budget = 10;
    while (!bus.sigint && budget > 0) begin
      tick(1);
      budget--;
    end
    chk("sigint_wait", bus.sigint, 1);
    bus.ack = 1; tick(1); bus.ack = 0;
    bus.eoi = 1; tick(1); bus.eoi = 0;
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clock) begin
    if (checkOn) begin
      chk("m_sigint", bus.sigint, (mPhase == 1));
      chk("m_in_service", bus.in_service, (mPhase == 2));
      chk("m_pending", bus.pending, mPending);
      chk("m_count", bus.count, mCount);
      if (mPhase != 0) chk("m_cause", bus.cause, mCause);
    end
  end

  initial begin
    int budget;
    reset = 1;
    bus.stop = 0; bus.irq_in = 0; bus.quantum_we = 0; bus.quantum_in = 0;
    bus.mask_we = 0; bus.mask_in = 0; bus.ack = 0; bus.eoi = 0;
    tick(2);
    checkOn = 1;
    chk("rst_sigint", bus.sigint, 0);
    chk("rst_cause", bus.cause, 0);
    chk("rst_pending", bus.pending, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_in_service", bus.in_service, 0);

    // Timer expiry with quantum 5
    reset = 0;
    bus.quantum_we = 1; bus.quantum_in = 5; tick(1); bus.quantum_we = 0;
    tick(4);
    chk("tmr_count4", bus.count, 4);
    chk("tmr_pend_pre", bus.pending, 0);
    tick(1);
    chk("tmr_pend_set", bus.pending, 4'b0001);
    chk("tmr_wrap", bus.count, 0);
    chk("tmr_sig_pre", bus.sigint, 0);
    tick(1);
    chk("tmr_sigint", bus.sigint, 1);
    chk("tmr_cause", bus.cause, 0);

    // Service with ack held 10 cycles: timer frozen
    bus.ack = 1; tick(1);
    chk("svc_pend_clr", bus.pending, 0);
    chk("svc_in_service", bus.in_service, 1);
    chk("svc_count", bus.count, 2);
    tick(9);
    chk("svc_frozen", bus.count, 2);
    bus.ack = 0; bus.eoi = 1; tick(1); bus.eoi = 0;
    chk("eoi_idle", bus.in_service, 0);
    tick(1);
    chk("eoi_resume", bus.count, 3);
    bus.quantum_we = 1; bus.quantum_in = 0; tick(1); bus.quantum_we = 0;

    // Two sources in one cycle: source 1 first, then source 2
    bus.irq_in = 3'b011; tick(1); bus.irq_in = 0;
    chk("ext_pend", bus.pending, 4'b0110);
    tick(1);
    chk("ext_cause1", bus.cause, 1);
    chk("ext_sig1", bus.sigint, 1);
    bus.ack = 1; tick(1); bus.ack = 0;
    chk("ext_pend_after_ack", bus.pending, 4'b0100);
    bus.eoi = 1; tick(1); bus.eoi = 0;
    tick(1);
    chk("ext_cause2", bus.cause, 2);
    chk("ext_sig2", bus.sigint, 1);

    // Timer expires while requesting cause 2: cause stays frozen
    bus.quantum_we = 1; bus.quantum_in = 3; tick(1); bus.quantum_we = 0;
    tick(3);
    chk("frz_pend", bus.pending, 4'b0101);
    chk("frz_cause", bus.cause, 2);
    tick(1);
    chk("frz_cause_late", bus.cause, 2);

    // ack coincides with a new rise on source 2: event kept
    bus.quantum_we = 1; bus.quantum_in = 0; bus.ack = 1; bus.irq_in = 3'b010; tick(1);
    bus.quantum_we = 0; bus.ack = 0; bus.irq_in = 0;
    chk("setwin_pend2", bus.pending[2], 1);
    chk("setwin_svc", bus.in_service, 1);
    bus.eoi = 1; tick(1); bus.eoi = 0;
    budget = 6;
    while (bus.pending != 0 && budget > 0) begin
      serviceOne();
      budget--;
    end
    chk("drain", bus.pending, 0);

    // Level held 20 cycles yields one event
    bus.irq_in = 3'b100; tick(2);
    chk("hold_cause3", bus.cause, 3);
    serviceOne();
    tick(16);
    chk("hold_pend", bus.pending, 0);
    chk("hold_sig", bus.sigint, 0);
    bus.irq_in = 0; tick(1);

    // Masked pending stays latched, fires on unmask
    bus.mask_we = 1; bus.mask_in = 4'b1101; tick(1); bus.mask_we = 0;
    bus.irq_in = 3'b001; tick(1); bus.irq_in = 0;
    tick(3);
    chk("mask_pend", bus.pending, 4'b0010);
    chk("mask_sig", bus.sigint, 0);
    bus.mask_we = 1; bus.mask_in = 4'b1111; tick(1); bus.mask_we = 0;
    tick(1);
    chk("unmask_sig", bus.sigint, 1);
    chk("unmask_cause", bus.cause, 1);
    serviceOne();

    // stop freezes the counter
    bus.quantum_we = 1; bus.quantum_in = 1000; tick(1); bus.quantum_we = 0;
    tick(3);
    chk("stop_pre", bus.count, 3);
    bus.stop = 1; tick(8);
    chk("stop_hold", bus.count, 3);
    bus.stop = 0; tick(1);
    chk("stop_resume", bus.count, 4);

    // Reset while in service with pending 1010
    bus.quantum_we = 1; bus.quantum_in = 0; tick(1); bus.quantum_we = 0;
    bus.irq_in = 3'b101; tick(1); bus.irq_in = 0;
    tick(1);
    bus.ack = 1; tick(1); bus.ack = 0;
    bus.irq_in = 3'b001; bus.mask_we = 1; bus.mask_in = 4'b0111; tick(1);
    bus.irq_in = 0; bus.mask_we = 0;
    chk("pre_rst_pend", bus.pending, 4'b1010);
    chk("pre_rst_svc", bus.in_service, 1);
    reset = 1; tick(1);
    chk("rst2_pend", bus.pending, 0);
    chk("rst2_sig", bus.sigint, 0);
    chk("rst2_svc", bus.in_service, 0);
    chk("rst2_count", bus.count, 0);
    chk("rst2_quantum", dut.quantumReg, 1000);
    chk("rst2_mask", dut.maskReg, 4'b1111);
    reset = 0; tick(2);
    chk("post_rst_sig", bus.sigint, 0);

    checkOn = 0;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
